ladybird_icache: RTL

LADYBIRD_ICACHE -- requirements
Module: ladybird_icache

---
 rtl/ladybird_icache.sv | 138 +++++++++++++
 1 files changed

// File: rtl/ladybird_icache.sv
// Direct-mapped, one-word-per-line instruction cache with a single outstanding
// memory read. Misses are bypassed to the core in the same cycle the data returns.
module ladybird_icache #(
  parameter int XLEN  = 32,
  parameter int LINES = 8
) (
  input  logic            clk,
  input  logic            nrst,
  input  logic [XLEN-1:0] pc,
  input  logic            pc_valid,
  output logic            pc_ready,
  output logic [XLEN-1:0] inst,
  output logic            inst_valid,
  input  logic            invalidate,
  output logic            mem_req,
  input  logic            mem_gnt,
  output logic [XLEN-1:0] mem_addr,
  input  logic            mem_rvalid,
  input  logic [XLEN-1:0] mem_rdata
);

  localparam int IDXW = $clog2(LINES);
  localparam int TAGW = XLEN - 2 - IDXW;

  typedef enum logic [1:0] {IDLE, LOOKUP, MISS_REQ, MISS_WAIT} state_t;

  state_t                 state_reg, state_next;
  logic [XLEN-3:0]        word_reg;
  logic [LINES-1:0]       valid_reg;
  logic                   inv_seen_reg;
  logic [XLEN-1:0]        inst_hold_reg;
  logic [TAGW+XLEN-1:0]   line_ram [LINES];
  logic [TAGW+XLEN-1:0]   rd_reg;

  logic                   handshake;
  logic [IDXW-1:0]        idx_in;
  logic [IDXW-1:0]        idx_reg;
  logic [TAGW-1:0]        tag_reg;
  logic [TAGW-1:0]        rd_tag;
  logic [XLEN-1:0]        rd_data;
  logic                   hit;
  logic                   install;
  logic                   unused_pc_bits;

  assign unused_pc_bits = ^pc[1:0];
  assign handshake      = pc_valid && pc_ready;
  assign idx_in         = pc[2 +: IDXW];
  assign idx_reg        = word_reg[IDXW-1:0];
  assign tag_reg        = word_reg[XLEN-3 -: TAGW];
  assign rd_tag         = rd_reg[TAGW+XLEN-1 -: TAGW];
  assign rd_data        = rd_reg[XLEN-1:0];
  assign hit            = valid_reg[idx_reg] && (rd_tag == tag_reg);
  assign mem_addr       = {word_reg, 2'b00};

  // An invalidate seen anywhere in the miss, including the fill cycle, blocks the install.
  assign install = (state_reg == MISS_WAIT) && mem_rvalid && !inv_seen_reg && !invalidate;

  // Tag+data array is read on the handshake so the line is ready in LOOKUP.
  always_ff @(posedge clk) begin
    if (install) begin
      line_ram[idx_reg] <= {tag_reg, mem_rdata};
    end
    if (handshake) begin
      rd_reg <= line_ram[idx_in];
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < LINES; gi++) begin : g_valid
      always_ff @(posedge clk) begin
        if (!nrst || invalidate) begin
          valid_reg[gi] <= 1'b0;
        end else if (install && (idx_reg == IDXW'(gi))) begin
          valid_reg[gi] <= 1'b1;
        end
      end
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (!nrst) begin
      state_reg     <= IDLE;
      word_reg      <= '0;
      inv_seen_reg  <= 1'b0;
      inst_hold_reg <= '0;
    end else begin
      state_reg <= state_next;
      if (handshake) begin
        word_reg <= pc[XLEN-1:2];
      end
      if (state_reg == IDLE) begin
        inv_seen_reg <= 1'b0;
      end else if (invalidate && (state_reg == MISS_REQ || state_reg == MISS_WAIT)) begin
        inv_seen_reg <= 1'b1;
      end
      if (inst_valid) begin
        inst_hold_reg <= inst;
      end
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:      if (pc_valid)   state_next = LOOKUP;
      LOOKUP:    state_next = hit ? IDLE : MISS_REQ;
      MISS_REQ:  if (mem_gnt)    state_next = MISS_WAIT;
      MISS_WAIT: if (mem_rvalid) state_next = IDLE;
      default:   state_next = IDLE;
    endcase
  end

  always_comb begin
    pc_ready   = 1'b0;
    mem_req    = 1'b0;
    inst_valid = 1'b0;
    inst       = inst_hold_reg;
    case (state_reg)
      IDLE:     pc_ready = 1'b1;
      LOOKUP: begin
        if (hit) begin
          inst_valid = 1'b1;
          inst       = rd_data;
        end
      end
      MISS_REQ: mem_req = 1'b1;
      MISS_WAIT: begin
        if (mem_rvalid) begin
          inst_valid = 1'b1;
          inst       = mem_rdata;
        end
      end
      default: ;
    endcase
  end

endmodule
